real_aes_cone_pipe: RTL and testbench
=====================================

Name: real_aes_cone_pipe

Overview:
- Parametrised, multi-channel, pipelined evaluator of the AES 10-input timing-cone function (function F, defined below).
- Each of NCH channels applies F to its own 10-bit input vector.
- The pipeline is STAGES deep, elastic, with valid/ready on both sides.
- Sits between the cone stimulus generator and the characterisation/compare logic in the AES timing-cone harness.

Parameters:
- NCH, 4: number of independent cone channels (1..16).
- STAGES, 2: pipeline register slices (1..8). Equals latency in cycles.
- CW, 16: width of each per-channel activity counter (2..32). Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  pipeline can accept this cycle.
- in_data  in  NCH*10  channel c, cone input i is in_data[c*10+i].
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_data  out  NCH  bit c is F(channel c inputs).
- cnt_clr  in  1  synchronous clear of the activity counters.
- act_cnt  out  NCH*CW  per-channel activity counters; constant 0 without the optional feature.

Behaviour:
- Definition of F, with inputs x0..x9:
  - g = ~x0 & ~x4 & ~x9
  - p = x8 & x5 & ~x1 & ~(x7 & g)
  - q = x6 & ~x7 & g
  - F = ~((x2 & x3) | (p & ~g) | (q & ~p))
- F is computed combinationally on in_data and captured into slice 0. Slices k = 1..STAGES-1 shift forward.
- Each slice holds a valid bit v_k and NCH data bits.
- Slice readiness: rdy_k = ~v_k | rdy_(k+1), with rdy_STAGES = out_ready. in_ready = rdy_0.
- A transfer occurs on in_valid & in_ready, and on out_valid & out_ready.
- out_valid = v_(STAGES-1). out_data = data of the last slice.
- Latency: a vector accepted in cycle t appears with out_valid=1 in cycle t+STAGES if no stall.
- Throughput: 1 vector/cycle when out_ready=1 continuously.
- Backpressure: out_data and out_valid stay stable while out_valid & ~out_ready. No vector is lost or duplicated.
- Full pipeline (all v_k=1) with out_ready=0: in_ready=0.
- Full pipeline with out_ready=1: the output transfer and input acceptance happen in the same cycle.
- Ordering is strictly FIFO.
- Reset, including mid-operation: all v_k=0, all slice data 0, out_valid=0, out_data=0, act_cnt=0, last-bit registers 0.
  - In-flight vectors are discarded.
  - in_ready=1 in the first cycle after rst deasserts.

Optional Feature:
- Macro: REAL_AES_CONE_ACT_CNT_EN.
- Defined:
  - On each output transfer, channel c compares out_data[c] with last_c (the bit from that channel's previous output transfer).
  - If they differ, cnt_c increments, saturating at 2^CW-1. last_c is then updated to out_data[c].
  - cnt_clr sets all cnt_c to 0. On a coincident toggle, clear wins for the count, but last_c is still updated.
  - act_cnt[c*CW +: CW] = cnt_c.
- Undefined: no counter or last-bit registers are built, act_cnt is tied to 0, and cnt_clr is ignored.

Decomposition:
- Package real_aes_cone_pkg:
  - localparam CONE_W = 10.
  - Input index constants X0..X9.
  - Function cone_f(logic [9:0]) returning F.
  - Typedef cone_vec_t (logic [CONE_W-1:0]).
- Sub-module real_aes_cone_slice: one elastic register slice with NCH-wide data and v/rdy chaining, instantiated STAGES times in a generate loop.
- Counters live in the top, inside an ifdef region.

Test Plan:
- Function check: NCH=4, STAGES=2. Channel vectors 0x000, 0x00C, 0x040, 0x121 accepted in cycle t -> at t+2, out_valid=1 and out_data=4'b0001 (channel 0 = 1, channels 1..3 = 0). Also vector 0x120 on channel 0 -> out_data[0]=1.
- Streaming: 16 back-to-back vectors with out_ready=1 -> 16 consecutive out_valid cycles starting 2 cycles after the first accept, in order. in_ready stays 1.
- Backpressure: out_ready=0 from cycle 3 while in_valid=1 -> in_ready drops after exactly STAGES accepts. out_data is held. Releasing out_ready drains in order with no loss.
- Reset mid-stream: rst=1 for 1 cycle with the pipeline full -> next cycle out_valid=0, out_data=0, in_ready=1. Nothing emerges until new input is accepted.
- Counter (macro defined, CW=2): channel 0 alternates 1,0,1,0,1 over 5 transfers -> act_cnt[1:0]=3 (saturated after 4 toggles). cnt_clr coincident with a toggle -> count reads 0. The next toggle gives 1.
- Macro undefined: same stimulus -> act_cnt stays 0. cnt_clr has no effect on out_data timing.

Source files
------------

// File: rtl/real_aes_cone_pkg.sv
// Shared definitions for the AES 10-input timing-cone pipeline.
// Holds the cone width, the input index names and the cone function itself.
package real_aes_cone_pkg;

    localparam int CONE_W = 10;

    localparam int X0 = 0;
    localparam int X1 = 1;
    localparam int X2 = 2;
    localparam int X3 = 3;
    localparam int X4 = 4;
    localparam int X5 = 5;
    localparam int X6 = 6;
    localparam int X7 = 7;
    localparam int X8 = 8;
    localparam int X9 = 9;

    typedef logic [CONE_W-1:0] cone_vec_t;

    // Evaluates the timing-cone function F on one 10-bit input vector.
    function automatic logic cone_f(input cone_vec_t x);
        logic g;
        logic p;
        logic q;
        g = ~x[X0] & ~x[X4] & ~x[X9];
        p = x[X8] & x[X5] & ~x[X1] & ~(x[X7] & g);
        q = x[X6] & ~x[X7] & g;
        return ~((x[X2] & x[X3]) | (p & ~g) | (q & ~p));
    endfunction

endpackage

// File: rtl/real_aes_cone_pipe_slice.sv
// One elastic register slice of the cone pipeline: a valid bit plus NCH result bits.
// The load enable is this slice's readiness, computed by the parent from the chain.
module real_aes_cone_slice #(
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           up_valid_i,
    input  logic [NCH-1:0] up_data_i,
    output logic           valid_o,
    output logic [NCH-1:0] data_o
);

    logic           valid_q;
    logic           valid_d;
    logic [NCH-1:0] data_q;
    logic [NCH-1:0] data_d;

    // When the slice can move, take the upstream valid; data only changes on a real vector.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    // Slice register with synchronous clear that drops any in-flight vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/real_aes_cone_pipe.sv
// Multi-channel elastic pipeline evaluating the AES timing-cone function per channel.
// Optional per-channel output activity counters are built when REAL_AES_CONE_ACT_CNT_EN is defined.
module real_aes_cone_pipe
    import real_aes_cone_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int STAGES = 2,
    parameter int CW     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*CONE_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH-1:0]        out_data,
    input  logic                  cnt_clr,
    output logic [NCH*CW-1:0]     act_cnt
);

    logic [NCH-1:0]    coneBits;
    logic [STAGES-1:0] stageValid;
    logic [STAGES-1:0] stageReady;
    logic [NCH-1:0]    stageData [STAGES];

    // Cone function applied to every channel's input vector before slice 0.
    always_comb begin
        coneBits = '0;
        for (int c = 0; c < NCH; c++) begin
            coneBits[c] = cone_f(in_data[c*CONE_W +: CONE_W]);
        end
    end

    // Slice k may move unless it and every slice after it are full and the consumer stalls;
    // this is the ready chain unrolled so no signal feeds back into itself.
    always_comb begin
        logic allFull;
        allFull    = 1'b1;
        stageReady = '0;
        for (int k = 0; k < STAGES; k++) begin
            allFull = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                allFull = allFull & stageValid[j];
            end
            stageReady[k] = out_ready | ~allFull;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic           upValid;
        logic [NCH-1:0] upData;
        if (k == 0) begin : g_head
            assign upValid = in_valid;
            assign upData  = coneBits;
        end else begin : g_tail
            assign upValid = stageValid[k-1];
            assign upData  = stageData[k-1];
        end
        real_aes_cone_slice #(.NCH(NCH)) u_slice (
            .clk        (clk),
            .rst        (rst),
            .load_i     (stageReady[k]),
            .up_valid_i (upValid),
            .up_data_i  (upData),
            .valid_o    (stageValid[k]),
            .data_o     (stageData[k])
        );
    end

    assign in_ready  = stageReady[0];
    assign out_valid = stageValid[STAGES-1];
    assign out_data  = stageData[STAGES-1];

`ifdef REAL_AES_CONE_ACT_CNT_EN
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] last_q;
    logic [NCH-1:0] last_d;
    logic           outFire;

    assign outFire = out_valid & out_ready;

    // Count output toggles per channel with saturation; a clear overrides the count but not the last bit.
    always_comb begin
        last_d = last_q;
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (outFire) begin
                if ((out_data[c] != last_q[c]) && (cnt_q[c] != {CW{1'b1}})) begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
                last_d[c] = out_data[c];
            end
            if (cnt_clr) begin
                cnt_d[c] = '0;
            end
        end
    end

    // Counter and last-bit registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            last_q <= last_d;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // Flatten the per-channel counters onto the output bus.
    always_comb begin
        act_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            act_cnt[c*CW +: CW] = cnt_q[c];
        end
    end
`else
    logic unusedCntClr;

    assign unusedCntClr = cnt_clr;
    assign act_cnt      = '0;
`endif

endmodule

// File: tb/tb_real_aes_cone_pipe.sv
// Self-checking bench for real_aes_cone_pipe: scoreboard plus behavioural cone/counter model.
module tb_real_aes_cone_pipe;

    localparam int NCH    = 4;
    localparam int STAGES = 2;
    localparam int CW     = 2;
    localparam int CMAX   = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [NCH*10-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NCH-1:0]      out_data;
    logic                cnt_clr;
    logic [NCH*CW-1:0]   act_cnt;

    real_aes_cone_pipe #(.NCH(NCH), .STAGES(STAGES), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .act_cnt   (act_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [NCH-1:0] exp;
        int             acc;
    } item_t;

    item_t sb[$];
    int    mCnt[NCH];
    bit    mLast[NCH];
    bit    rstSeen   = 1'b0;
    bit    strictLat = 1'b0;

    always @(posedge clk) cyc++;

    // Reference cone written straight from the boolean definition of F.
    function automatic bit refCone(input logic [9:0] v);
        bit x[10];
        bit g, p, q;
        for (int i = 0; i < 10; i++) x[i] = v[i];
        g = !x[0] && !x[4] && !x[9];
        p = x[8] && x[5] && !x[1] && !(x[7] && g);
        q = x[6] && !x[7] && g;
        return !((x[2] && x[3]) || (p && !g) || (q && !p));
    endfunction

    function automatic logic [NCH-1:0] refVec(input logic [NCH*10-1:0] d);
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = refCone(d[c*10 +: 10]);
        return r;
    endfunction

    function automatic logic [NCH*10-1:0] randData();
        logic [NCH*10-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*10 +: 10] = 10'($urandom);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: bounded wait expired", name);
    endtask

    // Present one vector and hold it until the pipeline accepts it.
    task automatic applyStimulus(input logic [NCH*10-1:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) failNote("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOut();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        failNote("out_valid_timeout");
    endtask

    task automatic waitEmpty();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        failNote("drain_timeout");
    endtask

    // Monitor: compares counters every cycle and pops the scoreboard on each output transfer.
    always @(negedge clk) begin
        item_t it;
        if (rstSeen) begin
            for (int c = 0; c < NCH; c++)
                checkOutput($sformatf("act_cnt[%0d]", c), 64'(act_cnt[c*CW +: CW]), 64'(mCnt[c]));
        end
        if (rst) begin
            sb.delete();
            for (int c = 0; c < NCH; c++) begin
                mCnt[c]  = 0;
                mLast[c] = 1'b0;
            end
            rstSeen = 1'b1;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_output: got %0h, expected no output", out_data);
                end else begin
                    it = sb.pop_front();
                    checkOutput("out_data", 64'(out_data), 64'(it.exp));
                    if (strictLat) checkOutput("latency", 64'(cyc - it.acc), 64'(STAGES));
`ifdef REAL_AES_CONE_ACT_CNT_EN
                    for (int c = 0; c < NCH; c++) begin
                        if (it.exp[c] != mLast[c] && mCnt[c] < CMAX) mCnt[c]++;
                        mLast[c] = it.exp[c];
                    end
`endif
                end
            end
`ifdef REAL_AES_CONE_ACT_CNT_EN
            if (cnt_clr) begin
                for (int c = 0; c < NCH; c++) mCnt[c] = 0;
            end
`endif
            if (in_valid && in_ready) sb.push_back('{refVec(in_data), cyc});
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepts;
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_act_cnt", 64'(act_cnt), 64'd0);

        // Function check with known vectors
        applyStimulus({10'h121, 10'h040, 10'h00C, 10'h000});
        waitOut();
        checkOutput("func_vec", 64'(out_data), 64'b0001);
        applyStimulus({30'h0, 10'h120});
        waitOut();
        checkOutput("func_120_ch0", 64'(out_data[0]), 64'd1);
        waitEmpty();

        // Streaming: back-to-back accepts, exact latency
        strictLat = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = randData();
            @(negedge clk);
            checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitEmpty();
        strictLat = 1'b0;

        // Backpressure: exactly STAGES accepts, output held
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = randData();
        accepts   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) accepts++;
            @(posedge clk);
            #1;
            in_data = randData();
        end
        @(negedge clk);
        checkOutput("bp_accepts", 64'(accepts), 64'(STAGES));
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sb.size() > 0) checkOutput("bp_hold", 64'(out_data), 64'(sb[0].exp));
            else failNote("bp_scoreboard_empty");
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitEmpty();

        // Reset mid-stream with a full pipeline
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = randData();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) failNote("fill_timeout");
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_out_data", 64'(out_data), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("mid_rst_quiet", 64'(out_valid), 64'd0);
        end

        // Counter: alternate channel 0 as 1,0,1,0,1
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            applyStimulus({30'h0, (i % 2 == 0) ? 10'h000 : 10'h00C});
        waitEmpty();
        @(negedge clk);
`ifdef REAL_AES_CONE_ACT_CNT_EN
        checkOutput("cnt_saturate", 64'(act_cnt[1:0]), 64'd3);
`else
        checkOutput("cnt_disabled", 64'(act_cnt[1:0]), 64'd0);
`endif
        // Clear coincident with a toggle, then one more toggle
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus({30'h0, 10'h00C});
        waitOut();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        checkOutput("cnt_clear_wins", 64'(act_cnt[1:0]), 64'd0);
        applyStimulus({30'h0, 10'h000});
        waitEmpty();
        @(negedge clk);
`ifdef REAL_AES_CONE_ACT_CNT_EN
        checkOutput("cnt_after_clear", 64'(act_cnt[1:0]), 64'd1);
`else
        checkOutput("cnt_after_clear", 64'(act_cnt[1:0]), 64'd0);
`endif

        // Randomised traffic with stalls, clears and occasional resets
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            in_data   = randData();
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        rst       = 1'b0;
        waitEmpty();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
